ads1115_scanner: RTL and testbench

ADS1115_SCANNER -- requirements
Module: ads1115_scanner

---
 rtl/ads1115_scanner.sv | 196 +++++++++++++++++++
 tb/tb_ads1115_scanner.sv | 292 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ads1115_scanner.sv
// ADS1115 round-robin scanner: per channel it writes the config register, waits for the
// conversion, sets the pointer to the conversion register, reads it and stores the result.
module ads1115_ch_slot (
  input  logic        i_clk,
  input  logic        i_rst_n,
  input  logic        i_wr,
  input  logic [15:0] i_data,
  output logic [15:0] o_data,
  output logic        o_valid
);
  logic [15:0] r_data;
  logic        r_valid;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_data  <= '0;
      r_valid <= 1'b0;
    end else if (i_wr) begin
      r_data  <= i_data;
      r_valid <= 1'b1;
    end
  end

  assign o_data  = r_data;
  assign o_valid = r_valid;
endmodule

module ads1115_scanner #(
  parameter int         NUM_CH    = 4,
  parameter logic [6:0] I2C_ADDR  = 7'h48,
  parameter logic [2:0] PGA       = 3'b001,
  parameter logic [2:0] DR        = 3'b100,
  parameter int         CONV_WAIT = 100000,
  parameter int         TIMEOUT   = 1000000
) (
  input  logic                 i_clk,
  input  logic                 i_rst_n,
  input  logic                 i_scan_en,
  input  logic                 i_trigger,
  output logic                 o_cmd_start,
  output logic [6:0]           o_addr_byte_in,
  output logic                 o_read_write,
  output logic [7:0]           o_register_byte_in,
  output logic [15:0]          o_data_byte_in,
  output logic                 o_only_register,
  input  logic                 i_i2c_done,
  input  logic                 i_i2c_nack,
  input  logic [15:0]          i_read_data,
  output logic [16*NUM_CH-1:0] o_ch_data,
  output logic [NUM_CH-1:0]    o_ch_valid,
  output logic                 o_sample_strobe,
  output logic [1:0]           o_cur_ch,
  output logic                 o_err
);
  typedef enum logic [3:0] {
    S_IDLE, S_CFG, S_CFG_W, S_CONV, S_PTR, S_PTR_W, S_RD, S_RD_W, S_STORE, S_ERR
  } state_t;

  typedef struct packed {
    logic        rw;
    logic        only;
    logic [7:0]  ptr;
    logic [15:0] data;
  } i2c_req_t;

  localparam logic [1:0]  LAST_CH = 2'(NUM_CH - 1);
  localparam logic [31:0] CW_LIM  = 32'(CONV_WAIT - 1);
  // Timeout counter starts one cycle after cmd_start, hence the -2.
  localparam logic [31:0] TO_LIM  = 32'(TIMEOUT - 2);

  function automatic i2c_req_t cfg_req(input logic [1:0] ch);
    cfg_req = '{rw: 1'b0, only: 1'b0, ptr: 8'h01,
                data: {1'b1, 1'b1, ch, PGA, 1'b1, DR, 3'b000, 2'b11}};
  endfunction

  state_t      r_state;
  i2c_req_t    r_req;
  logic        r_cmd_start;
  logic        r_strobe;
  logic        r_err;
  logic        r_pass;
  logic [1:0]  r_cur_ch;
  logic [31:0] r_cnt;

  logic        w_last;
  logic [1:0]  w_nxt;
  logic        w_store;
  logic [NUM_CH-1:0]       w_wr;
  logic [NUM_CH-1:0][15:0] w_ch_data;

  assign w_last  = (r_cur_ch == LAST_CH);
  assign w_nxt   = r_cur_ch + 2'd1;
  assign w_store = (r_state == S_RD_W) && i_i2c_done && !i_i2c_nack;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state     <= S_IDLE;
      r_req       <= '0;
      r_cmd_start <= 1'b0;
      r_strobe    <= 1'b0;
      r_err       <= 1'b0;
      r_pass      <= 1'b0;
      r_cur_ch    <= 2'd0;
      r_cnt       <= '0;
    end else begin
      r_cmd_start <= 1'b0;
      r_strobe    <= 1'b0;
      case (r_state)
        S_IDLE:
          if (i_scan_en || i_trigger) begin
            r_state     <= S_CFG;
            r_cur_ch    <= 2'd0;
            r_pass      <= i_trigger;
            r_req       <= cfg_req(2'd0);
            r_cmd_start <= 1'b1;
          end
        S_CFG, S_PTR, S_RD: begin
          r_state <= (r_state == S_CFG) ? S_CFG_W : (r_state == S_PTR) ? S_PTR_W : S_RD_W;
          r_cnt   <= '0;
        end
        S_CFG_W, S_PTR_W, S_RD_W:
          if (i_i2c_done) begin
            if (i_i2c_nack) begin
              r_state <= S_ERR;
              r_err   <= 1'b1;
            end else if (r_state == S_CFG_W) begin
              r_state <= S_CONV;
              r_cnt   <= '0;
            end else if (r_state == S_PTR_W) begin
              r_state     <= S_RD;
              r_req       <= '{rw: 1'b1, only: 1'b0, ptr: 8'h00, data: r_req.data};
              r_cmd_start <= 1'b1;
            end else begin
              r_state  <= S_STORE;
              r_strobe <= 1'b1;
              r_err    <= 1'b0;
            end
          end else if (r_cnt == TO_LIM) begin
            r_state <= S_ERR;
            r_err   <= 1'b1;
          end else begin
            r_cnt <= r_cnt + 32'd1;
          end
        S_CONV:
          if (r_cnt == CW_LIM) begin
            r_state     <= S_PTR;
            r_req       <= '{rw: 1'b0, only: 1'b1, ptr: 8'h00, data: r_req.data};
            r_cmd_start <= 1'b1;
          end else begin
            r_cnt <= r_cnt + 32'd1;
          end
        S_STORE, S_ERR:
          // A triggered pass keeps going after scan_en drops; otherwise stop after this channel.
          if (!w_last && (i_scan_en || r_pass)) begin
            r_state     <= S_CFG;
            r_cur_ch    <= w_nxt;
            r_req       <= cfg_req(w_nxt);
            r_cmd_start <= 1'b1;
          end else if (w_last && i_scan_en) begin
            r_state     <= S_CFG;
            r_cur_ch    <= 2'd0;
            r_pass      <= 1'b0;
            r_req       <= cfg_req(2'd0);
            r_cmd_start <= 1'b1;
          end else begin
            r_state <= S_IDLE;
            r_pass  <= 1'b0;
          end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  for (genvar k = 0; k < NUM_CH; k++) begin : g_ch
    assign w_wr[k] = w_store && (r_cur_ch == 2'(k));
    ads1115_ch_slot u_slot (
      .i_clk   (i_clk),
      .i_rst_n (i_rst_n),
      .i_wr    (w_wr[k]),
      .i_data  (i_read_data),
      .o_data  (w_ch_data[k]),
      .o_valid (o_ch_valid[k])
    );
  end

  assign o_ch_data          = w_ch_data;
  assign o_cmd_start        = r_cmd_start;
  assign o_addr_byte_in     = I2C_ADDR;
  assign o_read_write       = r_req.rw;
  assign o_register_byte_in = r_req.ptr;
  assign o_data_byte_in     = r_req.data;
  assign o_only_register    = r_req.only;
  assign o_sample_strobe    = r_strobe;
  assign o_cur_ch           = r_cur_ch;
  assign o_err              = r_err;
endmodule

// File: tb/tb_ads1115_scanner.sv
// Directed bench for ads1115_scanner: 4-channel instance with a scriptable I2C engine
// model (ack / nack / withhold), plus a 1-channel instance with an always-ack engine.
module tb_ads1115_scanner;
  localparam int CW = 5;
  localparam int TO = 20;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_mis = 0;

  // ---------------- 4-channel DUT ----------------
  logic        scan_en = 1'b0, trigger = 1'b0;
  logic        cmd_start, read_write, only_register, sample_strobe, err;
  logic [6:0]  addr_byte;
  logic [7:0]  reg_byte;
  logic [15:0] data_byte;
  logic        done = 1'b0, nack = 1'b0;
  logic [15:0] rdata = 16'h0;
  logic [63:0] ch_data;
  logic [3:0]  ch_valid;
  logic [1:0]  cur_ch;

  ads1115_scanner #(.NUM_CH(4), .CONV_WAIT(CW), .TIMEOUT(TO)) dut (
    .i_clk(clk), .i_rst_n(rst_n), .i_scan_en(scan_en), .i_trigger(trigger),
    .o_cmd_start(cmd_start), .o_addr_byte_in(addr_byte), .o_read_write(read_write),
    .o_register_byte_in(reg_byte), .o_data_byte_in(data_byte), .o_only_register(only_register),
    .i_i2c_done(done), .i_i2c_nack(nack), .i_read_data(rdata),
    .o_ch_data(ch_data), .o_ch_valid(ch_valid), .o_sample_strobe(sample_strobe),
    .o_cur_ch(cur_ch), .o_err(err));

  // Engine model state
  int          nack_ch = -1, hold_ch = -1;
  logic [15:0] base = 16'h0;
  logic        busy = 1'b0, pnack = 1'b0;
  int          lat = 0, cyc = 0;
  int          cmd_cnt = 0, rd_cnt = 0, stab_err = 0, hold_cyc = 0;
  logic [1:0]  mdl_ch = 2'd0;
  logic [25:0] held = '0;
  logic [25:0] log_q[$];
  int          strobe_cnt = 0, err_rises = 0, rise_cyc = 0;
  logic        err_d = 1'b0;

  always @(posedge clk) begin
    cyc  <= cyc + 1;
    done <= 1'b0;
    nack <= 1'b0;
    if (busy) begin
      if (rst_n && ({read_write, only_register, reg_byte, data_byte} != held))
        stab_err <= stab_err + 1;
      if (lat == 0) begin
        done  <= 1'b1;
        nack  <= pnack;
        rdata <= base + {14'd0, mdl_ch};
        busy  <= 1'b0;
      end else lat <= lat - 1;
    end else if (cmd_start) begin
      cmd_cnt <= cmd_cnt + 1;
      log_q.push_back({read_write, only_register, reg_byte, data_byte});
      held  <= {read_write, only_register, reg_byte, data_byte};
      pnack <= 1'b0;
      lat   <= 2;
      busy  <= 1'b1;
      if (read_write) rd_cnt <= rd_cnt + 1;
      if (!read_write && !only_register && reg_byte == 8'h01) begin
        mdl_ch <= data_byte[13:12];
        pnack  <= (int'(data_byte[13:12]) == nack_ch);
        if (int'(data_byte[13:12]) == hold_ch) begin
          hold_cyc <= cyc;
          busy     <= 1'b0;
        end
      end
    end
  end

  always @(posedge clk) begin
    err_d <= err;
    if (err && !err_d) begin
      err_rises <= err_rises + 1;
      rise_cyc  <= cyc;
    end
    if (sample_strobe) strobe_cnt <= strobe_cnt + 1;
  end

  // ---------------- 1-channel DUT ----------------
  logic        scan1 = 1'b0, trig1 = 1'b0;
  logic        cs1, rw1, only1, sst1, err1;
  logic [6:0]  addr1;
  logic [7:0]  reg1;
  logic [15:0] data1, chd1;
  logic        d1 = 1'b0, nack1 = 1'b0;
  logic [15:0] rdata1 = 16'h7FF1;
  logic [0:0]  val1;
  logic [1:0]  cur1;

  ads1115_scanner #(.NUM_CH(1), .CONV_WAIT(CW), .TIMEOUT(TO)) dut1 (
    .i_clk(clk), .i_rst_n(rst_n), .i_scan_en(scan1), .i_trigger(trig1),
    .o_cmd_start(cs1), .o_addr_byte_in(addr1), .o_read_write(rw1),
    .o_register_byte_in(reg1), .o_data_byte_in(data1), .o_only_register(only1),
    .i_i2c_done(d1), .i_i2c_nack(nack1), .i_read_data(rdata1),
    .o_ch_data(chd1), .o_ch_valid(val1), .o_sample_strobe(sst1),
    .o_cur_ch(cur1), .o_err(err1));

  logic b1 = 1'b0;
  int   l1 = 0, rd1_cnt = 0, cfg1_cnt = 0, cfg1_bad = 0, s1_cnt = 0, cur1_nz = 0;

  always @(posedge clk) begin
    d1 <= 1'b0;
    if (b1) begin
      if (l1 == 0) begin d1 <= 1'b1; b1 <= 1'b0; end
      else l1 <= l1 - 1;
    end else if (cs1) begin
      b1 <= 1'b1;
      l1 <= 1;
      if (rw1) rd1_cnt <= rd1_cnt + 1;
      if (!rw1 && !only1) begin
        cfg1_cnt <= cfg1_cnt + 1;
        if (data1 != 16'hC383 || reg1 != 8'h01) cfg1_bad <= cfg1_bad + 1;
      end
    end
    if (sst1) s1_cnt <= s1_cnt + 1;
    if (rst_n && cur1 != 2'd0) cur1_nz <= cur1_nz + 1;
  end

  // ---------------- helpers ----------------
  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_mis++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic int get_cnt(input int sel);
    case (sel)
      0:       get_cnt = strobe_cnt;
      1:       get_cnt = rd_cnt;
      default: get_cnt = s1_cnt;
    endcase
  endfunction

  task automatic wait_for(input string tag, input int sel, input int target);
    int n = 0;
    while (get_cnt(sel) < target && n < 2000) begin
      @(negedge clk);
      n++;
    end
    if (get_cnt(sel) < target) begin
      n_cmp++;
      n_mis++;
      $error("FAIL %s: timed out, count %0d expected %0d", tag, get_cnt(sel), target);
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic pulse_trigger();
    @(negedge clk);
    trigger = 1'b1;
    @(negedge clk);
    trigger = 1'b0;
  endtask

  int q0, s0, c0, e0;

  initial begin
    rst_n = 1'b1;
    #2 rst_n = 1'b0;
    repeat (2) @(negedge clk);

    // Reset state
    check("rst_cmd_start", 64'(cmd_start), 64'd0);
    check("rst_strobe",    64'(sample_strobe), 64'd0);
    check("rst_err",       64'(err), 64'd0);
    check("rst_valid",     64'(ch_valid), 64'd0);
    check("rst_data",      ch_data, 64'd0);
    check("rst_cur_ch",    64'(cur_ch), 64'd0);
    check("rst_fields",    64'({read_write, only_register, reg_byte, data_byte}), 64'd0);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    check("idle_no_cmd",   64'(cmd_cnt), 64'd0);

    // Continuous scan, all acks
    base = 16'h8A10;
    q0 = log_q.size(); s0 = strobe_cnt;
    scan_en = 1'b1;
    wait_for("scan_4_strobes", 0, s0 + 4);
    check("addr",          64'(addr_byte), 64'h48);
    check("cfg_ch0",       64'(log_q[q0 + 0]), 64'({1'b0, 1'b0, 8'h01, 16'hC383}));
    check("ptr_ch0",       64'(log_q[q0 + 1][25:16]), 64'({1'b0, 1'b1, 8'h00}));
    check("rd_ch0",        64'(log_q[q0 + 2][25:24]), 64'(2'b10));
    check("cfg_ch1",       64'(log_q[q0 + 3]), 64'({1'b0, 1'b0, 8'h01, 16'hD383}));
    check("cfg_ch3",       64'(log_q[q0 + 9]), 64'({1'b0, 1'b0, 8'h01, 16'hF383}));
    check("scan_valid",    64'(ch_valid), 64'hF);
    check("scan_data",     ch_data, 64'h8A13_8A12_8A11_8A10);
    scan_en = 1'b0;
    repeat (200) @(negedge clk);
    c0 = cmd_cnt;
    repeat (100) @(negedge clk);
    check("scan_stop_idle", 64'(cmd_cnt - c0), 64'd0);
    check("stable_fields",  64'(stab_err), 64'd0);

    // Single triggered pass; a second trigger mid-pass is ignored
    do_reset();
    base = 16'h0123;
    s0 = strobe_cnt; c0 = cmd_cnt;
    pulse_trigger();
    repeat (40) @(negedge clk);
    pulse_trigger();
    repeat (300) @(negedge clk);
    check("trig_strobes",  64'(strobe_cnt - s0), 64'd4);
    check("trig_cmds",     64'(cmd_cnt - c0), 64'd12);
    check("trig_valid",    64'(ch_valid), 64'hF);
    check("trig_data",     ch_data, 64'h0126_0125_0124_0123);
    repeat (100) @(negedge clk);
    check("trig_idle",     64'(cmd_cnt - c0), 64'd12);

    // NACK on ch2 config
    do_reset();
    base = 16'hF000; nack_ch = 2;
    s0 = strobe_cnt; c0 = cmd_cnt; e0 = err_rises;
    pulse_trigger();
    repeat (300) @(negedge clk);
    nack_ch = -1;
    check("nack_err_rise", 64'(err_rises - e0), 64'd1);
    check("nack_err_clr",  64'(err), 64'd0);
    check("nack_valid",    64'(ch_valid), 64'hB);
    check("nack_strobes",  64'(strobe_cnt - s0), 64'd3);
    check("nack_cmds",     64'(cmd_cnt - c0), 64'd10);
    check("nack_ch3",      64'(ch_data[63:48]), 64'hF003);

    // Engine withholds done on ch1 config
    do_reset();
    base = 16'h2200; hold_ch = 1;
    s0 = strobe_cnt; c0 = cmd_cnt;
    pulse_trigger();
    repeat (300) @(negedge clk);
    hold_ch = -1;
    check("to_latency",    64'(rise_cyc - hold_cyc), 64'(TO));
    check("to_valid",      64'(ch_valid), 64'hD);
    check("to_strobes",    64'(strobe_cnt - s0), 64'd3);
    check("to_cmds",       64'(cmd_cnt - c0), 64'd10);
    check("to_err_clr",    64'(err), 64'd0);

    // Reset during the ch1 read
    do_reset();
    base = 16'h4000;
    c0 = rd_cnt;
    scan_en = 1'b1;
    wait_for("rdw_reach", 1, c0 + 2);
    check("pre_rst_valid", 64'(ch_valid), 64'h1);
    rst_n = 1'b0;
    #1;
    check("mid_rst_cmd",   64'(cmd_start), 64'd0);
    check("mid_rst_valid", 64'(ch_valid), 64'd0);
    check("mid_rst_data",  ch_data, 64'd0);
    check("mid_rst_cur",   64'(cur_ch), 64'd0);
    check("mid_rst_fields", 64'({read_write, only_register, reg_byte, data_byte}), 64'd0);
    scan_en = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    s0 = strobe_cnt; c0 = cmd_cnt;
    repeat (60) @(negedge clk);
    check("post_rst_cmds", 64'(cmd_cnt - c0), 64'd0);
    check("post_rst_strb", 64'(strobe_cnt - s0), 64'd0);
    check("post_rst_err",  64'(err), 64'd0);

    // Single-channel instance
    scan1 = 1'b1;
    wait_for("one_ch_strobes", 2, 3);
    check("one_ch_data",   64'(chd1), 64'h7FF1);
    check("one_ch_valid",  64'(val1), 64'd1);
    scan1 = 1'b0;
    repeat (100) @(negedge clk);
    check("one_ch_cfg",    64'(cfg1_bad), 64'd0);
    check("one_ch_cur",    64'(cur1_nz), 64'd0);
    check("one_ch_per_rd", 64'(s1_cnt), 64'(rd1_cnt));
    check("one_ch_per_cfg", 64'(s1_cnt), 64'(cfg1_cnt));
    check("one_ch_err",    64'(err1), 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end
endmodule
